// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: data width, NOP encoding, fetch-stage FSM states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package rv32i_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    STALL    = 2'd2,
    REDIRECT = 2'd3
  } ifState_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] alignWord(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_register.sv
// Program counter: reset load, redirect load, +4 advance (wraps modulo 2^32).
// Latency: new PC visible one cycle after the request.
// Backpressure: holds its value whenever neither advance nor redirect is asserted.
module pc_register
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            redirect,
  input  logic [XLEN-1:0] target,
  output logic [XLEN-1:0] pc
);

  // Redirect outranks sequential advance; reset outranks both.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= alignWord(RESET_PC);
    end else if (redirect) begin
      pc <= alignWord(target);
    end else if (advance) begin
      pc <= pc + 32'd4;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register for a synchronous-read imem.
// Latency: instruction at imem_addr=A reaches ifid_instr two rising edges later.
// Backpressure: PCWrite=0 holds PC/fetch tracking, IFIDWrite=0 holds IF/ID; redirect overrides both.
// Build option: define IF_STALL_COUNTER_EN to synthesize the saturating stall_cycles counter.
module if_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic            IFIDWrite,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_instr,
  output logic            ifid_valid,
  output logic [XLEN-1:0] stall_cycles
);

  ifState_t        state;
  ifState_t        stateNext;
  logic            redirect;
  logic            advance;
  logic            loadFetch;
  logic            holdIfid;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] fetchPc;
  logic            fetchValid;
  logic [XLEN-1:0] heldInstr;
  logic [XLEN-1:0] fetchData;

  pc_register #(
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk      (clk),
    .rst      (rst),
    .advance  (advance),
    .redirect (redirect),
    .target   (branch_target),
    .pc       (pc)
  );

  assign imem_addr = pc;

  // While stalled the memory re-reads the held PC, so imem_rdata runs one
  // word ahead of fetchPc; the word belonging to fetchPc was captured on the
  // last non-stall cycle and is replayed from heldInstr.
  assign fetchData = (state == STALL) ? heldInstr : imem_rdata;
  assign holdIfid  = !IFIDWrite || ((state == STALL) && !PCWrite);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BOOT;
    end else begin
      state <= stateNext;
    end
  end

  // Next state and PC/fetch controls; a taken branch beats any stall outside BOOT.
  always_comb begin
    stateNext = state;
    redirect  = 1'b0;
    advance   = 1'b0;
    loadFetch = 1'b0;
    case (state)
      BOOT: begin
        advance   = PCWrite;
        loadFetch = PCWrite;
        stateNext = RUN;
      end
      default: begin
        if (branch_taken) begin
          redirect  = 1'b1;
          stateNext = REDIRECT;
        end else if (PCWrite) begin
          advance   = 1'b1;
          loadFetch = 1'b1;
          stateNext = RUN;
        end else begin
          stateNext = STALL;
        end
      end
    endcase
  end

  // Track the address whose data returns next cycle; wrong-path fetches are marked invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetchPc    <= '0;
      fetchValid <= 1'b0;
    end else if (redirect) begin
      fetchPc    <= pc;
      fetchValid <= 1'b0;
    end else if (loadFetch) begin
      fetchPc    <= pc;
      fetchValid <= 1'b1;
    end
  end

  // Capture the returning word on every non-stall cycle for replay after a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      heldInstr <= NOP;
    end else if (state != STALL) begin
      heldInstr <= imem_rdata;
    end
  end

  // IF/ID register: flush beats hold, invalid fetches become NOP bubbles.
  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      ifid_valid <= 1'b0;
      ifid_instr <= NOP;
      ifid_pc    <= '0;
    end else if (!holdIfid) begin
      ifid_valid <= fetchValid;
      ifid_instr <= fetchValid ? fetchData : NOP;
      ifid_pc    <= fetchPc;
    end
  end

`ifdef IF_STALL_COUNTER_EN
  logic            countStall;
  logic [XLEN-1:0] stallCnt;

  assign countStall   = (state == STALL) || ((state == RUN) && !PCWrite);
  assign stall_cycles = stallCnt;

  // Saturating count of stall cycles; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt <= '0;
    end else if (countStall && (stallCnt != '1)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed scenarios plus randomized traffic vs. a fetch model.
// Latency: imem model answers one cycle after imem_addr is presented.
// Backpressure: PCWrite/IFIDWrite driven randomly (mostly tied, occasionally PCWrite-only).
module tb_if_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;
  localparam logic [31:0] NOPI   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  // Reference model: where fetch is, what is in flight, what sits in IF/ID.
  logic [31:0] mPc, mFpc, mIdPc, mIdInstr, mCnt;
  logic        mFv, mIdValid, mBoot, mStall, mRedir;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .PCWrite       (PCWrite),
    .IFIDWrite     (IFIDWrite),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .ifid_pc       (ifid_pc),
    .ifid_instr    (ifid_instr),
    .ifid_valid    (ifid_valid),
    .stall_cycles  (stall_cycles)
  );

  always #5 clk = ~clk;

  // Distinct, address-derived content for every word of instruction memory.
  function automatic logic [31:0] instrAt(input logic [31:0] a);
    return {a[31:2] ^ 30'h2AAA_AAAA, 2'b11};
  endfunction

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_rdata <= instrAt(imem_addr);

  function automatic logic [31:0] expCnt(input logic [31:0] n);
`ifdef IF_STALL_COUNTER_EN
    return n;
`else
    return (n & 32'h0);
`endif
  endfunction

  // One clock of the reference model, from the inputs applied at this edge.
  task automatic modelStep();
    logic redir, idHold, wasBoot;
    if (rst) begin
      mPc = RST_PC & 32'hFFFF_FFFC; mFpc = 0; mFv = 0;
      mIdPc = 0; mIdInstr = NOPI; mIdValid = 0; mCnt = 0;
      mBoot = 1; mStall = 0; mRedir = 0;
    end else begin
      wasBoot = mBoot;
      redir   = branch_taken && !wasBoot;
      idHold  = !IFIDWrite || (mStall && !PCWrite);
      if (mStall || (!wasBoot && !mRedir && !PCWrite))
        if (mCnt != 32'hFFFF_FFFF) mCnt = mCnt + 1;
      if (redir) begin
        mIdValid = 0; mIdInstr = NOPI; mIdPc = 0;
      end else if (!idHold) begin
        mIdValid = mFv; mIdPc = mFpc; mIdInstr = mFv ? instrAt(mFpc) : NOPI;
      end
      if (redir) begin
        mFpc = mPc; mFv = 0; mPc = {branch_target[31:2], 2'b00};
      end else if (PCWrite) begin
        mFpc = mPc; mFv = 1; mPc = mPc + 32'd4;
      end
      mStall = !redir && !PCWrite && !wasBoot;
      mRedir = redir;
      mBoot  = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1; PCWrite = 1; IFIDWrite = 1; branch_taken = 0; branch_target = 0;
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; PCWrite = 0; IFIDWrite = 0; branch_taken = 1; branch_target = 32'h777;
    tick(); tick();
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL reset_addr got %h exp %h", imem_addr, RST_PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    checks++; if (ifid_instr !== NOPI) begin errors++; $display("FAIL reset_instr got %h exp %h", ifid_instr, NOPI); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", ifid_pc); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", stall_cycles); end
    rst = 0; PCWrite = 1; IFIDWrite = 1; branch_taken = 0;
  endtask

  task automatic test_sequential();
    doReset();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (imem_addr !== RST_PC + 4 * i) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", i, imem_addr, RST_PC + 4 * i); end
      checks++;
      if (ifid_valid !== (i >= 2)) begin errors++; $display("FAIL seq_valid%0d got %b exp %b", i, ifid_valid, (i >= 2)); end
      if (i >= 2) begin
        checks++;
        if (ifid_pc !== RST_PC + 4 * (i - 2)) begin errors++; $display("FAIL seq_pc%0d got %h exp %h", i, ifid_pc, RST_PC + 4 * (i - 2)); end
        checks++;
        if (ifid_instr !== instrAt(RST_PC + 4 * (i - 2))) begin errors++; $display("FAIL seq_instr%0d got %h exp %h", i, ifid_instr, instrAt(RST_PC + 4 * (i - 2))); end
      end
      tick();
    end
  endtask

  task automatic test_stall();
    doReset();
    tick(); tick();
    PCWrite = 0; IFIDWrite = 0;
    for (int i = 1; i <= 2; i++) begin
      tick();
      checks++; if (imem_addr !== 32'h108) begin errors++; $display("FAIL stall_addr%0d got %h exp 108", i, imem_addr); end
      checks++; if (ifid_pc !== 32'h100) begin errors++; $display("FAIL stall_pc%0d got %h exp 100", i, ifid_pc); end
      checks++; if (ifid_instr !== instrAt(32'h100)) begin errors++; $display("FAIL stall_instr%0d got %h exp %h", i, ifid_instr, instrAt(32'h100)); end
      checks++; if (stall_cycles !== expCnt(i)) begin errors++; $display("FAIL stall_cnt%0d got %0d exp %0d", i, stall_cycles, expCnt(i)); end
    end
    PCWrite = 1; IFIDWrite = 1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (ifid_pc !== 32'h104 + 4 * i) begin errors++; $display("FAIL resume_pc%0d got %h exp %h", i, ifid_pc, 32'h104 + 4 * i); end
      checks++; if (ifid_instr !== instrAt(32'h104 + 4 * i)) begin errors++; $display("FAIL resume_instr%0d got %h exp %h", i, ifid_instr, instrAt(32'h104 + 4 * i)); end
    end
  endtask

  task automatic test_branch();
    doReset();
    tick(); tick(); tick();
    branch_taken = 1; branch_target = 32'h203;
    tick();
    branch_taken = 0;
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL br_addr got %h exp 200", imem_addr); end
    checks++; if (ifid_instr !== NOPI) begin errors++; $display("FAIL br_flush_instr got %h exp %h", ifid_instr, NOPI); end
    checks++; if (ifid_pc !== 32'h0) begin errors++; $display("FAIL br_flush_pc got %h exp 0", ifid_pc); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL br_bubble%0d got %b exp 0", i, ifid_valid); end
      tick();
    end
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h200) begin errors++; $display("FAIL br_land got v=%b pc=%h exp v=1 pc=200", ifid_valid, ifid_pc); end
    checks++; if (ifid_instr !== instrAt(32'h200)) begin errors++; $display("FAIL br_land_instr got %h exp %h", ifid_instr, instrAt(32'h200)); end
  endtask

  task automatic test_branch_in_stall();
    doReset();
    tick(); tick(); tick();
    PCWrite = 0; IFIDWrite = 0;
    tick();
    branch_taken = 1; branch_target = 32'h3F0;
    tick();
    checks++; if (imem_addr !== 32'h3F0) begin errors++; $display("FAIL bstall_addr got %h exp 3f0", imem_addr); end
    checks++; if (ifid_instr !== NOPI || ifid_valid !== 1'b0) begin errors++; $display("FAIL bstall_flush got %h/%b exp %h/0", ifid_instr, ifid_valid, NOPI); end
    branch_target = 32'h501; PCWrite = 1; IFIDWrite = 1;
    tick();
    branch_taken = 0;
    checks++; if (imem_addr !== 32'h500) begin errors++; $display("FAIL redir_again got %h exp 500", imem_addr); end
    tick(); tick();
    checks++; if (ifid_valid !== 1'b1 || ifid_pc !== 32'h500) begin errors++; $display("FAIL redir_land got v=%b pc=%h exp v=1 pc=500", ifid_valid, ifid_pc); end
  endtask

  task automatic test_wrap();
    doReset();
    tick();
    branch_taken = 1; branch_target = 32'hFFFF_FFFE;
    tick();
    branch_taken = 0;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top got %h exp fffffffc", imem_addr); end
    tick();
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_zero got %h exp 0", imem_addr); end
    tick(); tick();
    checks++; if (ifid_pc !== 32'h0 || ifid_instr !== instrAt(32'h0)) begin errors++; $display("FAIL wrap_ifid got %h/%h exp 0/%h", ifid_pc, ifid_instr, instrAt(32'h0)); end
  endtask

  task automatic test_reset_in_stall();
    doReset();
    tick(); tick();
    PCWrite = 0; IFIDWrite = 0;
    tick(); tick();
    rst = 1; branch_taken = 1; branch_target = 32'h40;
    tick();
    rst = 0; branch_taken = 0; PCWrite = 1; IFIDWrite = 1;
    checks++; if (imem_addr !== RST_PC) begin errors++; $display("FAIL rststall_addr got %h exp %h", imem_addr, RST_PC); end
    checks++; if (ifid_valid !== 1'b0) begin errors++; $display("FAIL rststall_valid got %b exp 0", ifid_valid); end
    checks++; if (stall_cycles !== 32'h0) begin errors++; $display("FAIL rststall_cnt got %0d exp 0", stall_cycles); end
  endtask

  task automatic test_random();
    doReset();
    for (int n = 0; n < 3000; n++) begin
      logic stall;
      rst           = ($urandom_range(0, 199) == 0);
      branch_taken  = ($urandom_range(0, 9) == 0);
      branch_target = $urandom;
      stall         = ($urandom_range(0, 3) == 0);
      PCWrite       = !stall;
      IFIDWrite     = !stall && ($urandom_range(0, 15) != 0);
      tick();
      checks++; if (imem_addr !== mPc) begin errors++; $display("FAIL rnd_addr@%0d got %h exp %h", n, imem_addr, mPc); end
      checks++; if (ifid_valid !== mIdValid) begin errors++; $display("FAIL rnd_valid@%0d got %b exp %b", n, ifid_valid, mIdValid); end
      checks++; if (ifid_instr !== mIdInstr) begin errors++; $display("FAIL rnd_instr@%0d got %h exp %h", n, ifid_instr, mIdInstr); end
      if (mIdValid) begin
        checks++; if (ifid_pc !== mIdPc) begin errors++; $display("FAIL rnd_pc@%0d got %h exp %h", n, ifid_pc, mIdPc); end
      end
      checks++; if (stall_cycles !== expCnt(mCnt)) begin errors++; $display("FAIL rnd_cnt@%0d got %0d exp %0d", n, stall_cycles, expCnt(mCnt)); end
    end
    rst = 0; branch_taken = 0; PCWrite = 1; IFIDWrite = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; PCWrite = 1; IFIDWrite = 1; branch_taken = 0; branch_target = 0;
    @(negedge clk);
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_branch_in_stall();
    test_wrap();
    test_reset_in_stall();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] SHALL be treated as zero.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 PCWrite  input  1  from hazard detection unit; 0 SHALL hold the PC.
REQ-005 IFIDWrite  input  1  from hazard detection unit; 0 SHALL hold the IF/ID register.
REQ-006 branch_taken  input  1  redirect request, resolved in EX.
REQ-007 branch_target  input  32  redirect address.
REQ-008 imem_addr  output  32  instruction memory address; synchronous-read memory, data valid one cycle later.
REQ-009 imem_rdata  input  32  instruction returned for the previous cycle's imem_addr.
REQ-010 ifid_pc  output  32  PC of the instruction in IF/ID.
REQ-011 ifid_instr  output  32  instruction in IF/ID.
REQ-012 ifid_valid  output  1  1 = ifid_instr is a real instruction, 0 = bubble.
REQ-013 stall_cycles  output  32  stall counter (see Configuration).

Function
REQ-014 imem_addr SHALL equal the PC register directly (no combinational path from any input).
REQ-015 A fetch register pair (fetch_pc, fetch_valid) SHALL track the address in flight, loaded when PCWrite=1 or a redirect occurs.
REQ-016 FSM states: BOOT, RUN, STALL, REDIRECT.
REQ-017 BOOT: entered on reset; lasts exactly one cycle; fetch_valid=0; next state RUN.
REQ-018 RUN: PCWrite=1 -> PC <= PC+4, fetch_valid <= 1; PCWrite=0 -> STALL, PC and fetch register held.
REQ-019 STALL: PC, fetch_pc, fetch_valid, IF/ID held while PCWrite=0; PCWrite=1 -> RUN with PC+4.
REQ-020 branch_taken=1 in any state except BOOT SHALL have priority over PCWrite=0: PC <= {branch_target[31:2],2'b00}, fetch_valid <= 0, IF/ID flushed, next state REDIRECT.
REQ-021 REDIRECT: lasts one cycle; squashes the wrong-path return data (fetch_valid already 0); then RUN rules apply, including a second branch_taken.
REQ-022 Flush: ifid_valid <= 0, ifid_instr <= NOP (32'h0000_0013), ifid_pc <= 0; flush SHALL override IFIDWrite=0.
REQ-023 IFIDWrite=1, no flush: ifid_instr <= imem_rdata, ifid_pc <= fetch_pc, ifid_valid <= fetch_valid; if fetch_valid=0, ifid_instr <= NOP.
REQ-024 PC increment SHALL wrap modulo 2^32 (32'hFFFF_FFFC + 4 -> 32'h0).
REQ-025 PCWrite=1 with IFIDWrite=0 (illegal from hazard unit) SHALL still hold IF/ID and advance PC; no assertion required.
REQ-026 Fetch-to-IF/ID latency: an instruction at address A SHALL appear in ifid_instr two rising edges after imem_addr=A, absent stalls.

Reset
REQ-027 On rst=1 at a rising edge: PC=RESET_PC, state=BOOT, fetch_valid=0, fetch_pc=0, ifid_valid=0, ifid_instr=NOP, ifid_pc=0, stall_cycles=0.
REQ-028 rst SHALL override every other input, including branch_taken, and SHALL abort any stall or redirect in progress.

Configuration
REQ-029 Macro IF_STALL_COUNTER_EN defined: stall_cycles increments by 1 each cycle state is STALL or PCWrite=0 in RUN, saturating at 32'hFFFF_FFFF, cleared only by reset.
REQ-030 Macro undefined: stall_cycles SHALL be constant 0 and no counter register SHALL be synthesized.

Structure
REQ-031 Shared package rv32i_pkg SHALL hold: NOP encoding 32'h0000_0013, XLEN=32, the if_stage FSM state typedef.
REQ-032 One sub-module pc_register (PC hold/increment/redirect/reset) SHALL be instantiated; FSM and IF/ID register stay in if_stage.

Verification
REQ-033 Reset RESET_PC=32'h100, run 4 cycles, no stall -> imem_addr 100,104,108,10C; ifid_valid first 1 two edges after rst release with ifid_pc=32'h100.
REQ-034 PCWrite=IFIDWrite=0 for 2 cycles at imem_addr=32'h108 -> imem_addr, ifid_pc, ifid_instr unchanged both cycles; stall_cycles=2 with macro, 0 without.
REQ-035 branch_taken=1, branch_target=32'h203 -> next imem_addr=32'h200, ifid_valid=0 for 2 cycles, then ifid_pc=32'h200.
REQ-036 branch_taken=1 while PCWrite=IFIDWrite=0 -> redirect wins: imem_addr=target, ifid_instr=32'h13, ifid_valid=0.
REQ-037 PC at 32'hFFFF_FFFC, PCWrite=1 -> imem_addr=32'h0 next cycle.
REQ-038 rst asserted during STALL -> next cycle imem_addr=RESET_PC, ifid_valid=0, stall_cycles=0.
